// File: rtl/mult_div_pkg.sv
// ============================================================================
// mult_div_pkg : shared encodings for the iterative signed multiply/divide
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mult_div_pkg;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

endpackage

`default_nettype wire

// File: rtl/mult_div_abs.sv
// ============================================================================
// md_abs : combinational 32-bit two's-complement conditional negate
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_abs (
  input  logic [31:0] val_i,
  input  logic        neg_i,
  output logic [31:0] res_o
);

  assign res_o = neg_i ? (~val_i + 32'd1) : val_i;

endmodule

`default_nettype wire

// File: rtl/mult_div.sv
// ============================================================================
// mult_div : 32-bit signed shift-add multiply / restoring divide, 34-cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       mop_q, mop_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [31:0] a_mag, b_mag, fix_lo, fix_hi, hi_res;
  logic        fix_hi_neg;
  logic [32:0] add_a, add_b, add_res;

  md_abs u_abs_a  (.val_i(a_i),          .neg_i(a_i[31]),    .res_o(a_mag));
  md_abs u_abs_b  (.val_i(b_i),          .neg_i(b_i[31]),    .res_o(b_mag));
  md_abs u_fix_lo (.val_i(acc_q[31:0]),  .neg_i(neg_q),      .res_o(fix_lo));
  md_abs u_fix_hi (.val_i(acc_q[63:32]), .neg_i(fix_hi_neg), .res_o(fix_hi));

  // DIV: hi holds remainder (dividend sign). MULT: 64-bit negate, where the
  // upper half only receives the +1 carry when the lower half is zero.
  assign fix_hi_neg = (op_q == OP_DIV) ? rneg_q : neg_q;
  assign hi_res = (op_q == OP_MULT && neg_q && acc_q[31:0] != 32'd0) ?
                  ~acc_q[63:32] : fix_hi;

  // Single shared adder: add for MULT, trial subtract of shifted remainder for DIV.
  assign add_a   = (op_q == OP_DIV) ? acc_q[63:31] : {1'b0, acc_q[63:32]};
  assign add_b   = {1'b0, mop_q};
  assign add_res = (op_q == OP_DIV) ? (add_a - add_b) : (add_a + add_b);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mop_d      = mop_q;
    op_d       = op_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    div_zero_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          op_d    = op_e'(op_i);
          mop_d   = (op_i == OP_DIV) ? b_mag : a_mag;
          acc_d   = (op_i == OP_DIV) ? {32'd0, a_mag} : {32'd0, b_mag};
          neg_d   = a_i[31] ^ b_i[31];
          rneg_d  = a_i[31];
          dz_d    = (op_i == OP_DIV) && (b_i == 32'd0);
        end
      end
      ST_CALC: begin
        if (op_q == OP_DIV)
          acc_d = add_res[32] ? {acc_q[62:0], 1'b0}
                              : {add_res[31:0], acc_q[30:0], 1'b1};
        else
          acc_d = acc_q[0] ? {add_res, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1))
          state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (!dz_q) begin
          hi_d = hi_res;
          lo_d = fix_lo;
        end
      end
      ST_DONE: begin
        done_o     = 1'b1;
        div_zero_o = dz_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mop_q   <= '0;
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mop_q   <= mop_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div.sv
// ============================================================================
// tb_mult_div : directed vectors with queued expectations and a done monitor
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_s = '0, b_s = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb_q[$];

  mult_div dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .op_i(op),
    .a_i(a_s), .b_i(b_s), .busy_o(busy), .done_o(done),
    .div_zero_o(div_zero), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        check("done_cycle", cyc, e.at);
      end
    end else if (div_zero) begin
      checks++;
      failures++;
      $display("FAIL div_zero_outside_done: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int at);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.at = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 10) begin
        check({name, "_calc_hi"}, hi, mdl_hi);
        check({name, "_calc_lo"}, lo, mdl_lo);
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic do_op(input string name, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
    @(negedge clk);
    start = 1'b1; op = o; a_s = a; b_s = b;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(ehi, elo, edz, cyc + 33);
    wait_done(name);
    mdl_hi = ehi;
    mdl_lo = elo;
  endtask

  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset_n = 1'b1;

    do_op("mul_7_m3",   1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
    do_op("div_100_7",  1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    do_op("mul_prime",  1'b0, 32'h66666666, 32'h2AAAAAAB, 32'h11111111, 32'h22222222, 1'b0);
    do_op("div_zero",   1'b1, 32'd5,        32'd0,        32'h11111111, 32'h22222222, 1'b1);
    do_op("mul_min",    1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0);
    do_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);

    // start held high: operands change mid-op, re-accept in IDLE after DONE
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_s = 32'd3; b_s = 32'd5;
    @(posedge clk); #1;
    e0 = cyc;
    push_exp(32'd0, 32'd15, 1'b0, e0 + 33);
    a_s = 32'd100; b_s = 32'd100;
    wait_done("held1");
    mdl_hi = 32'd0; mdl_lo = 32'd15;
    a_s = 32'd2; b_s = 32'd9;
    push_exp(32'd0, 32'd18, 1'b0, e0 + 35 + 33);
    @(posedge clk); #1;
    check("held_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("held2");
    mdl_hi = 32'd0; mdl_lo = 32'd18;

    // reset while CALC counter = 10, with a concurrent start
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_s = 32'h12345; b_s = 32'h777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    reset_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle", {31'd0, busy}, 32'd0);
    mdl_hi = 32'd0; mdl_lo = 32'd0;

    do_op("mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule

`default_nettype wire
